drum_mul_arbiter: RTL and testbench

- Shares one `drum` approximate signed multiplier among NREQ requesters.
- Round-robin arbitration and a valid/ready handshake on every requester port.
- Two-stage registered pipeline (operand stage, result stage) with full backpressure and a tagged response port.
- Sits between requester logic (e.g. RAM-mapped operand slots) and result storage, replacing ad-hoc direct wiring to the multiplier.

---
 rtl/drum_arb_pkg.sv | 28 ++
 rtl/drum.sv | 61 ++++++
 rtl/drum_mul_arbiter_rr_arbiter.sv | 48 ++++
 rtl/drum_mul_arbiter.sv | 89 ++++++++
 tb/tb_drum_mul_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/drum_arb_pkg.sv
// Shared constants and the round-robin pick helper for the drum multiplier arbiter.
package drum_arb_pkg;

    localparam int DRUM_N = 8;
    localparam int DRUM_K = 4;

    // Widest requester vector rr_pick can handle; callers zero-extend into it.
    localparam int RR_MAX = 32;

    // One-hot grant of the first set bit of valid, searching upward from ptr
    // and wrapping at nreq. Returns all zero when nothing is valid.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0] valid,
        input int unsigned       ptr,
        input int unsigned       nreq = RR_MAX
    );
        logic [RR_MAX-1:0] gnt;
        int unsigned       idx;
        gnt = '0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = ptr + i;
            if (idx >= nreq) idx = idx - nreq;
            if (i < nreq && gnt == '0 && valid[idx]) gnt[idx] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/drum.sv
// DRUM approximate signed multiplier: keeps k bits from each operand's leading
// one (LSB forced to 1 when bits were dropped), multiplies, shifts back.
// Signs are handled in one's-complement form.
module drum #(
    parameter int k = 4,
    parameter int n = 8,
    parameter int m = 8
) (
    input  logic [n-1:0]   a,
    input  logic [m-1:0]   b,
    output logic [n+m-1:0] r
);

    logic [n-1:0]     abs_a;
    logic [m-1:0]     abs_b;
    logic [k-1:0]     seg_a, seg_b;
    int               sh_a, sh_b;
    logic [2*k-1:0]   prod;
    logic [n+m-1:0]   mag;
    logic             neg;

    assign neg   = a[n-1] ^ b[m-1];
    assign abs_a = a[n-1] ? ~a : a;
    assign abs_b = b[m-1] ? ~b : b;

    // Leading-one detect and k-bit segment for operand a.
    always_comb begin : seg_a_sel
        int lead;
        lead = 0;
        for (int i = 0; i < n; i++) if (abs_a[i]) lead = i;
        if (lead >= k) begin
            sh_a  = lead - k + 1;
            seg_a = k'(abs_a >> sh_a) | k'(1);
        end else begin
            sh_a  = 0;
            seg_a = abs_a[k-1:0];
        end
    end

    // Leading-one detect and k-bit segment for operand b.
    always_comb begin : seg_b_sel
        int lead;
        lead = 0;
        for (int i = 0; i < m; i++) if (abs_b[i]) lead = i;
        if (lead >= k) begin
            sh_b  = lead - k + 1;
            seg_b = k'(abs_b >> sh_b) | k'(1);
        end else begin
            sh_b  = 0;
            seg_b = abs_b[k-1:0];
        end
    end

    // Small core product, scaled back up and re-signed.
    always_comb begin
        prod = seg_a * seg_b;
        mag  = (n+m)'(prod) << (sh_a + sh_b);
        r    = neg ? ~mag : mag;
    end

endmodule

// File: rtl/drum_mul_arbiter_rr_arbiter.sv
// Round-robin arbiter: owns the rotating pointer and produces a one-hot grant.
module rr_arbiter
    import drum_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         valid,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    grant_any
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]    rr_ptr;
    logic [RR_MAX-1:0] valid_ext;
    logic [RR_MAX-1:0] pick;
    logic              unused_pick;

    // Widen the request vector to the helper's fixed width.
    always_comb begin
        valid_ext            = '0;
        valid_ext[NREQ-1:0]  = valid;
    end

    assign pick        = rr_pick(valid_ext, 32'(rr_ptr), NREQ);
    assign unused_pick = ^pick;
    assign grant       = en ? pick[NREQ-1:0] : '0;
    assign grant_any   = |grant;

    // Encode the one-hot grant to an index.
    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) if (grant[i]) grant_id = IDW'(i);
    end

    // Pointer moves just past the winner so it goes last next time.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end

endmodule

// File: rtl/drum_mul_arbiter.sv
// Shares one drum multiplier among NREQ requesters behind a round-robin arbiter
// and a two-stage (operand, result) pipeline with full backpressure.
module drum_mul_arbiter
    import drum_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = DRUM_N,
    parameter int K    = DRUM_K
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*N-1:0]          rsp_data,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);

    logic           adv1, adv2;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   sel_a, sel_b;

    logic           s1_valid, s2_valid;
    logic [N-1:0]   s1_a, s1_b;
    logic [IDW-1:0] s1_id;
    logic [2*N-1:0] drum_r;

    // A stage may load when the stage ahead of it is empty or draining.
    assign adv2 = !s2_valid | rsp_ready;
    assign adv1 = !s1_valid | adv2;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv1),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_id  (gnt_id),
        .grant_any (gnt_any)
    );

    assign sel_a = req_a[gnt_id*N +: N];
    assign sel_b = req_b[gnt_id*N +: N];

    // Operand stage: capture the granted requester's operands and tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (adv1) begin
            s1_valid <= gnt_any;
            s1_a     <= sel_a;
            s1_b     <= sel_b;
            s1_id    <= gnt_id;
        end
    end

    drum #(.k(K), .n(N), .m(N)) u_drum (
        .a (s1_a),
        .b (s1_b),
        .r (drum_r)
    );

    // Result stage: hold the product and tag until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            rsp_data <= drum_r;
            rsp_id   <= s1_id;
        end
    end

    assign rsp_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Directed bench for drum_mul_arbiter: accepts push hand-computed results into a
// queue, a monitor pops and compares on every response transfer.
module tb_drum_mul_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][N-1:0] a_v, b_v;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [2*N-1:0]        rsp_data;
    logic                  busy;

    logic [15:0]           exp_v [NREQ];

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;

    drum_mul_arbiter #(.NREQ(NREQ), .N(N), .K(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (a_v),
        .req_b     (b_v),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Accept watcher: grant must be one-hot; each accept queues its expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i])
                    exp_q.push_back(rsp_t'{2'(i), exp_v[i]});
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && rsp_valid === 1'b1 && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response",
                         rsp_id, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        @(posedge clk); #1;
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] e);
        bit got;
        got = 1'b0;
        req_valid[i] = 1'b1;
        a_v[i] = a;
        b_v[i] = b;
        exp_v[i] = e;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        chk("issue_accept", 32'(got), 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        rsp_ready = 1'b1;
        req_valid = '0;
        a_v = '0;
        b_v = '0;
        for (int i = 0; i < NREQ; i++) exp_v[i] = '0;

        do_reset();

        // Exact-range single op, latency 2.
        req_valid = 4'b0010; a_v[1] = 8'd7; b_v[1] = 8'd9; exp_v[1] = 16'd63;
        @(negedge clk); chk("single_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("lat1_rsp_valid", 32'(rsp_valid), 0);
        chk("lat1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat2_rsp_valid", 32'(rsp_valid), 1);
        tick(2);

        // Approximation and one's-complement sign.
        issue(0, 8'd100, 8'd100, 16'h2A40);
        issue(0, 8'hFE, 8'd3, 16'hFFFC);
        tick(3);
        chk("approx_drained", 32'(exp_q.size()), 0);
        chk("approx_idle", 32'(busy), 0);

        // Round-robin with all requesters valid.
        do_reset();
        a_v[0] = 8'd3;   b_v[0] = 8'd5;  exp_v[0] = 16'h000F;
        a_v[1] = 8'hFD;  b_v[1] = 8'd4;  exp_v[1] = 16'hFFF7;
        a_v[2] = 8'd20;  b_v[2] = 8'd10; exp_v[2] = 16'h00DC;
        a_v[3] = 8'd15;  b_v[3] = 8'd15; exp_v[3] = 16'h00E1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k >= 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((k - 2) % 4));
            end
        end
        @(posedge clk); #1; req_valid = '0;
        tick(4);
        chk("rr_drained", 32'(exp_q.size()), 0);

        // Backpressure: two accepts, then frozen output.
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk); chk("bp_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk); chk("bp_grant1", 32'(req_ready), 32'b0010);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(req_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_id", 32'(rsp_id), 0);
            chk("bp_rsp_data", 32'(rsp_data), 32'h000F);
            chk("bp_busy", 32'(busy), 1);
        end

        // One-cycle release: response and accept on the same edge.
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk); chk("sim_grant", 32'(req_ready), 32'b0100);
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        chk("sim_busy", 32'(busy), 1);
        chk("sim_rsp_id", 32'(rsp_id), 1);
        chk("sim_rsp_data", 32'(rsp_data), 32'hFFF7);
        chk("sim_ready_low", 32'(req_ready), 0);

        // Drain: nothing lost or duplicated.
        @(posedge clk); #1; req_valid = '0; rsp_ready = 1'b1;
        tick(4);
        chk("bp_drained", 32'(exp_q.size()), 0);
        chk("bp_idle", 32'(busy), 0);

        // Reset with two ops in flight.
        rsp_ready = 1'b0;
        a_v[0] = 8'd7; b_v[0] = 8'd9; exp_v[0] = 16'd63;
        req_valid = 4'b0011;
        @(negedge clk); chk("mid_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk); chk("mid_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk); chk("mid_full_busy", 32'(busy), 1);
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk); chk("post_rst_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk); chk("post_rst_grant3", 32'(req_ready), 32'b1000);
        @(posedge clk); #1; req_valid = '0;
        issue(2, 8'd20, 8'd10, 16'h00DC);
        tick(4);

        chk("final_queue_empty", 32'(exp_q.size()), 0);
        chk("final_idle", 32'(busy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
